// File: rtl/rst_sequencer_if.sv
// Reset-sequencer signal bundle: per-domain reset/ready, software request/ack
// and status. The sequencer uses master; its environment uses slave.
interface rst_sequencer_if #(
   parameter int N_DOM = 4
);
   logic [N_DOM-1:0] dom_rst;
   logic [N_DOM-1:0] dom_rdy;
   logic             sw_req;
   logic [N_DOM-1:0] sw_mask;
   logic             sw_ack;
   logic             all_up;
   logic [N_DOM-1:0] timeout_err;

   modport master (
      output dom_rst, sw_ack, all_up, timeout_err,
      input  dom_rdy, sw_req, sw_mask
   );

   modport slave (
      input  dom_rst, sw_ack, all_up, timeout_err,
      output dom_rdy, sw_req, sw_mask
   );
endinterface

// File: rtl/rst_sequencer.sv
// Releases functional reset domains one at a time, lowest index first,
// waiting for each domain's ready (or a timeout) before moving on. Supports
// software re-reset of a domain and all of its dependents while running.
module rst_sequencer #(
   parameter int N_DOM   = 4,
   parameter int DELAY   = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic            clk,
   input  logic            rst,
   rst_sequencer_if.master bus
);
   localparam int CMAX = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT,
      S_GAP,
      S_RUN,
      S_SWHOLD
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [IW-1:0]    cur, cur_nxt;
   logic [N_DOM-1:0] dom_rst_q, dom_rst_nxt;
   logic [N_DOM-1:0] err_q, err_nxt;
   logic             sw_seq, sw_seq_nxt;
   logic             ack_pend, ack_pend_nxt;
   logic             sw_ack_q, sw_ack_nxt;
   logic [IW-1:0]    k_low;
   logic [N_DOM-1:0] dep_mask;

   logic delay_done, to_done, rdy_cur, last_dom, sw_go, sw_nop;

   assign delay_done = (cnt == CW'(DELAY - 1));
   assign to_done    = (cnt == CW'(TIMEOUT - 1));
   assign rdy_cur    = bus.dom_rdy[cur];
   assign last_dom   = (cur == IW'(N_DOM - 1));
   assign sw_go      = bus.sw_req && (bus.sw_mask != '0);
   assign sw_nop     = bus.sw_req && (bus.sw_mask == '0);

   assign bus.dom_rst     = dom_rst_q;
   assign bus.timeout_err = err_q;
   assign bus.sw_ack      = sw_ack_q;
   assign bus.all_up      = (state == S_RUN);

   // State and datapath registers; rst forces every reset value and drops a pending ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_HOLD;
         cnt       <= '0;
         cur       <= '0;
         dom_rst_q <= '1;
         err_q     <= '0;
         sw_seq    <= 1'b0;
         ack_pend  <= 1'b0;
         sw_ack_q  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cur       <= cur_nxt;
         dom_rst_q <= dom_rst_nxt;
         err_q     <= err_nxt;
         sw_seq    <= sw_seq_nxt;
         ack_pend  <= ack_pend_nxt;
         sw_ack_q  <= sw_ack_nxt;
      end
   end

   // Next-state decision: hold/gap timing, ready-or-timeout exit, software entry from RUN.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_HOLD, S_SWHOLD: if (delay_done) state_nxt = S_WAIT;
         S_WAIT:           if (rdy_cur || to_done) state_nxt = last_dom ? S_RUN : S_GAP;
         S_GAP:            if (delay_done) state_nxt = S_WAIT;
         S_RUN:            if (sw_go) state_nxt = S_SWHOLD;
         default:          state_nxt = S_HOLD;
      endcase
   end

   // Next values of counter, domain index, reset/error flags and the ack pulse.
   always_comb begin
      cnt_nxt      = (state_nxt != state || state == S_RUN) ? '0 : cnt + 1'b1;
      cur_nxt      = cur;
      dom_rst_nxt  = dom_rst_q;
      err_nxt      = err_q;
      sw_seq_nxt   = sw_seq;
      ack_pend_nxt = 1'b0;
      sw_ack_nxt   = 1'b0;

      // Lowest requested domain; it and every domain above it get reset.
      k_low = '0;
      for (int unsigned i = N_DOM; i > 0; i--) begin
         if (bus.sw_mask[i-1]) k_low = IW'(i - 1);
      end
      dep_mask = '0;
      for (int unsigned j = 0; j < N_DOM; j++) begin
         if (j >= 32'(k_low)) dep_mask[j] = 1'b1;
      end

      unique case (state)
         S_HOLD, S_SWHOLD: begin
            if (delay_done) dom_rst_nxt[cur] = 1'b0;
         end
         S_WAIT: begin
            // Ready on the timeout edge wins: no error is flagged.
            if (!rdy_cur && to_done) err_nxt[cur] = 1'b1;
            if ((rdy_cur || to_done) && last_dom) begin
               ack_pend_nxt = sw_seq;
               sw_seq_nxt   = 1'b0;
            end
         end
         S_GAP: begin
            if (delay_done) begin
               cur_nxt              = cur + 1'b1;
               dom_rst_nxt[cur_nxt] = 1'b0;
            end
         end
         S_RUN: begin
            // Ack lands one cycle after all_up rises, or right after an empty request.
            sw_ack_nxt = ack_pend || sw_nop;
            if (sw_go) begin
               dom_rst_nxt = dom_rst_q | dep_mask;
               cur_nxt     = k_low;
               sw_seq_nxt  = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_rst_sequencer.sv
// Randomized bench for rst_sequencer. Expected release/exit times come from
// an arithmetic timeline model: release = start + DELAY, exit = release +
// min(ready latency, TIMEOUT), next release = exit + DELAY.
module tb_rst_sequencer;
   localparam int N  = 4;
   localparam int D  = 8;
   localparam int TO = 100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rst_sequencer_if #(.N_DOM(N)) bus ();

   rst_sequencer #(.N_DOM(N), .DELAY(D), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [N-1:0] m_rst;
   logic [N-1:0] m_err;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Runs one bring-up starting at domain k; t=0 is the edge that started it.
   task automatic run_seq(input int k, input bit sw, input bit tied,
                          input logic [N-1:0] to_mask, input bit pulse_gap);
      int r   [N];
      int x   [N];
      int lat [N];
      bit er  [N];
      int xl, t_pulse;
      logic [N-1:0] e_rst, e_err, rdy;
      for (int i = 0; i < N; i++) begin
         r[i] = 0; x[i] = 0; lat[i] = 1; er[i] = 1'b0;
      end
      for (int i = k; i < N; i++) begin
         if (to_mask[i])      lat[i] = TO + 1 + int'($urandom_range(0, 3));
         else if (tied)       lat[i] = 1;
         else begin
            case ($urandom_range(0, 9))
               0:       lat[i] = 1;
               1:       lat[i] = TO;
               2:       lat[i] = TO + 1;
               default: lat[i] = int'($urandom_range(1, 15));
            endcase
         end
         if (i == k) r[i] = D;
         else        r[i] = x[i-1] + D;
         er[i] = (lat[i] > TO);
         x[i]  = r[i] + (er[i] ? TO : lat[i]);
      end
      xl      = x[N-1];
      t_pulse = x[k] + 2;
      e_err   = m_err;
      for (int t = 0; t <= xl + 3; t++) begin
         if (t > 0) begin
            for (int i = 0; i < N; i++) begin
               if (i < k || t <= r[i] || t > x[i]) rdy[i] = tied ? 1'b1 : 1'($urandom_range(0, 1));
               else                                 rdy[i] = (t >= r[i] + lat[i]);
            end
            bus.dom_rdy = rdy;
            bus.sw_req  = pulse_gap && (t == t_pulse);
            bus.sw_mask = N'($urandom_range(1, 2**N - 1));
            step();
         end
         e_err = m_err;
         for (int i = 0; i < N; i++) begin
            if (i < k) e_rst[i] = m_rst[i];
            else begin
               e_rst[i] = (t < r[i]);
               if (er[i] && t >= x[i]) e_err[i] = 1'b1;
            end
         end
         check("dom_rst",     32'(bus.dom_rst),     32'(e_rst));
         check("all_up",      32'(bus.all_up),      32'(t >= xl));
         check("sw_ack",      32'(bus.sw_ack),      32'(sw && t == xl + 1));
         check("timeout_err", 32'(bus.timeout_err), 32'(e_err));
      end
      bus.sw_req = 1'b0;
      m_rst = '0;
      m_err = e_err;
   endtask

   task automatic power_up(input bit tied, input logic [N-1:0] to_mask, input bit pulse_gap);
      rst         = 1'b1;
      bus.sw_req  = 1'b0;
      bus.dom_rdy = '0;
      m_rst       = '1;
      m_err       = '0;
      repeat (3) step();
      rst = 1'b0;
      run_seq(0, 1'b0, tied, to_mask, pulse_gap);
   endtask

   task automatic idle();
      repeat ($urandom_range(1, 4)) begin
         bus.dom_rdy = N'($urandom);
         step();
         check("idle_up",  32'(bus.all_up),  32'(1));
         check("idle_rst", 32'(bus.dom_rst), 32'(0));
      end
   endtask

   task automatic sw_start(input logic [N-1:0] m, input bit tied);
      int k = 0;
      for (int i = N - 1; i >= 0; i--) if (m[i]) k = i;
      bus.sw_mask = m;
      bus.sw_req  = 1'b1;
      step();
      bus.sw_req  = 1'b0;
      run_seq(k, 1'b1, tied, '0, 1'b0);
   endtask

   task automatic sw_nop_check();
      bus.sw_mask = '0;
      bus.sw_req  = 1'b1;
      step();
      bus.sw_req  = 1'b0;
      check("nop_ack",     32'(bus.sw_ack),  32'(1));
      check("nop_rst",     32'(bus.dom_rst), 32'(0));
      check("nop_up",      32'(bus.all_up),  32'(1));
      step();
      check("nop_ack_end", 32'(bus.sw_ack),  32'(0));
      check("nop_up_end",  32'(bus.all_up),  32'(1));
   endtask

   initial begin
      rst         = 1'b1;
      bus.dom_rdy = '0;
      bus.sw_req  = 1'b0;
      bus.sw_mask = '0;

      power_up(1'b1, '0, 1'b0);
      sw_nop_check();
      idle();
      sw_start(4'b0100, 1'b1);
      sw_nop_check();
      repeat (6) begin
         idle();
         sw_start(N'($urandom_range(1, 2**N - 1)), 1'b0);
      end

      power_up(1'b1, 4'b0010, 1'b1);
      repeat (4) begin
         idle();
         sw_start(N'($urandom_range(1, 2**N - 1)), 1'b0);
      end
      sw_nop_check();

      // Reset while waiting on domain 2 (ready never comes for it).
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      bus.dom_rdy = 4'b0011;
      repeat (30) step();
      check("pre_rst_dom", 32'(bus.dom_rst), 32'(4'b1000));
      rst = 1'b1;
      step();
      check("rst_dom",  32'(bus.dom_rst),     32'(4'b1111));
      check("rst_up",   32'(bus.all_up),      32'(0));
      check("rst_err",  32'(bus.timeout_err), 32'(0));
      check("rst_ack",  32'(bus.sw_ack),      32'(0));

      power_up(1'b0, '0, 1'b1);
      repeat (3) begin
         idle();
         sw_start(N'($urandom_range(1, 2**N - 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
